// File: rtl/axi4stream_sink_pkg.sv
// Shared types and constants for the AXI4-Stream sink: ready modes, packet states, LFSR setup.
package axi4stream_sink_pkg;

    typedef enum logic [1:0] {
        RDY_ALWAYS  = 2'd0,
        RDY_NEVER   = 2'd1,
        RDY_PATTERN = 2'd2,
        RDY_LFSR    = 2'd3
    } rdy_mode_t;

    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } pkt_state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Left-shifting Fibonacci form of x^16+x^14+x^13+x^11+1; taps at bits 15,13,12,10.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/axi4stream_sink_fifo.sv
// Synchronous capture FIFO with full/empty flags; the read port holds the last popped
// entry while empty.
module axi4stream_sink_fifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_full;
    logic             w_empty;
    logic             w_do_push;
    logic             w_do_pop;
    logic [AW-1:0]    w_rd_idx;

    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_do_push = i_push & ~w_full;
    assign w_do_pop  = i_pop & ~w_empty;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst && w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end

    // When empty, point one slot back so the last popped entry stays on the port.
    assign w_rd_idx = w_empty ? (r_rd_ptr[AW-1:0] - AW'(1)) : r_rd_ptr[AW-1:0];
    assign o_rdata  = r_mem[w_rd_idx];
    assign o_full   = w_full;
    assign o_empty  = w_empty;

endmodule

// File: rtl/axi4stream_slv_sink.sv
// AXI4-Stream slave sink: programmable TREADY backpressure, capture FIFO, beat/byte/packet
// counters. Optional stream pattern checker enabled by AXIS_SINK_PATTERN_CHECK_EN.
module axi4stream_slv_sink
    import axi4stream_sink_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned HAS_TLAST  = 1,
    parameter int unsigned HAS_TKEEP  = 0,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic [DATA_WIDTH-1:0]   s_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_tkeep,
    input  logic                    s_tlast,
    input  logic                    s_tvalid,
    output logic                    s_tready,
    input  logic [1:0]              rdy_mode,
    input  logic [7:0]              rdy_pattern,
    output logic [DATA_WIDTH-1:0]   cap_tdata,
    output logic [DATA_WIDTH/8-1:0] cap_tkeep,
    output logic                    cap_tlast,
    output logic                    cap_valid,
    input  logic                    cap_ready,
    output logic [CNT_WIDTH-1:0]    beat_cnt,
    output logic [CNT_WIDTH-1:0]    byte_cnt,
    output logic [CNT_WIDTH-1:0]    pkt_cnt,
    output logic                    in_pkt,
    output logic                    err
);

    localparam int unsigned KW  = DATA_WIDTH / 8;
    localparam int unsigned NBW = $clog2(KW + 1);
    localparam int unsigned FW  = DATA_WIDTH + KW + 1;

    logic                 r_gate;
    logic                 w_gate_d;
    logic [2:0]           r_phase;
    logic [15:0]          r_lfsr;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_accept;
    logic [KW-1:0]        w_keep;
    logic                 w_last;
    logic [NBW-1:0]       w_nbytes;
    logic [FW-1:0]        w_rdata;
    logic [CNT_WIDTH-1:0] r_beat_cnt;
    logic [CNT_WIDTH-1:0] r_byte_cnt;
    logic [CNT_WIDTH-1:0] r_pkt_cnt;
    logic [CNT_WIDTH:0]   w_beat_sum;
    logic [CNT_WIDTH:0]   w_byte_sum;
    logic [CNT_WIDTH:0]   w_pkt_sum;
    pkt_state_t           r_state;
    pkt_state_t           w_state_d;

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_gate  <= 1'b0;
            r_phase <= 3'd0;
            r_lfsr  <= LFSR_SEED;
        end else begin
            r_gate  <= w_gate_d;
            r_phase <= r_phase + 3'd1;
            r_lfsr  <= lfsr_next(r_lfsr);
        end
    end

    always_comb begin
        w_gate_d = 1'b0;
        case (rdy_mode_t'(rdy_mode))
            RDY_ALWAYS:  w_gate_d = 1'b1;
            RDY_NEVER:   w_gate_d = 1'b0;
            RDY_PATTERN: w_gate_d = rdy_pattern[r_phase];
            RDY_LFSR:    w_gate_d = r_lfsr[0];
            default:     w_gate_d = 1'b0;
        endcase
    end

    // Masked by areset so upstream never sees a handshake the reset will discard.
    assign s_tready = r_gate & ~w_full & ~areset;
    assign w_accept = s_tvalid & s_tready;
    assign w_keep   = (HAS_TKEEP != 0) ? s_tkeep : {KW{1'b1}};
    assign w_last   = (HAS_TLAST != 0) & s_tlast;

    always_comb begin
        w_nbytes = '0;
        for (int unsigned i = 0; i < KW; i++) begin
            w_nbytes = w_nbytes + NBW'(w_keep[i]);
        end
    end

    axi4stream_sink_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (aclk),
        .i_rst   (areset),
        .i_push  (w_accept),
        .i_wdata ({w_last, w_keep, s_tdata}),
        .i_pop   (cap_ready),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign cap_tdata = w_rdata[DATA_WIDTH-1:0];
    assign cap_tkeep = w_rdata[DATA_WIDTH +: KW];
    assign cap_tlast = w_rdata[FW-1];
    assign cap_valid = ~w_empty;

    // Sums carry one extra bit; a set MSB means the counter saturates at all-ones.
    always_comb begin
        w_beat_sum = {1'b0, r_beat_cnt} + (CNT_WIDTH+1)'(1);
        w_byte_sum = {1'b0, r_byte_cnt} + (CNT_WIDTH+1)'(w_nbytes);
        w_pkt_sum  = {1'b0, r_pkt_cnt} + (CNT_WIDTH+1)'(1);
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_beat_cnt <= '0;
            r_byte_cnt <= '0;
            r_pkt_cnt  <= '0;
        end else if (w_accept) begin
            r_beat_cnt <= w_beat_sum[CNT_WIDTH] ? '1 : w_beat_sum[CNT_WIDTH-1:0];
            r_byte_cnt <= w_byte_sum[CNT_WIDTH] ? '1 : w_byte_sum[CNT_WIDTH-1:0];
            if (w_last) begin
                r_pkt_cnt <= w_pkt_sum[CNT_WIDTH] ? '1 : w_pkt_sum[CNT_WIDTH-1:0];
            end
        end
    end

    assign beat_cnt = r_beat_cnt;
    assign byte_cnt = r_byte_cnt;
    assign pkt_cnt  = r_pkt_cnt;

    always_ff @(posedge aclk) begin
        if (areset) r_state <= IDLE;
        else        r_state <= w_state_d;
    end

    always_comb begin
        w_state_d = r_state;
        if (w_accept && (HAS_TLAST != 0)) begin
            case (r_state)
                IDLE:    if (!w_last) w_state_d = IN_PKT;
                IN_PKT:  if (w_last)  w_state_d = IDLE;
                default: w_state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        in_pkt = (r_state == IN_PKT);
    end

`ifdef AXIS_SINK_PATTERN_CHECK_EN
    logic [7:0] r_exp;
    logic       r_err;
    logic       w_mismatch;

    // Kept lanes are contiguous from lane 0, so lane i carries the stream's byte exp+i.
    always_comb begin
        w_mismatch = 1'b0;
        for (int unsigned i = 0; i < KW; i++) begin
            if ((i < 32'(w_nbytes)) && (s_tdata[8*i +: 8] != (r_exp + 8'(i)))) begin
                w_mismatch = 1'b1;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_exp <= 8'd0;
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_exp <= r_exp + 8'(w_nbytes);
            if (w_mismatch) r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_axi4stream_slv_sink.sv
// Scoreboard bench for axi4stream_slv_sink (32-bit data, TKEEP and TLAST enabled).
module tb_axi4stream_slv_sink;

    localparam int unsigned DW = 32;
    localparam int unsigned KW = DW / 8;
    localparam int BOUND = 300;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
    } beat_t;

    logic          aclk = 1'b0;
    logic          areset = 1'b1;
    logic [DW-1:0] s_tdata = '0;
    logic [KW-1:0] s_tkeep = '0;
    logic          s_tlast = 1'b0;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic [1:0]    rdy_mode = 2'd0;
    logic [7:0]    rdy_pattern = 8'hFF;
    logic [DW-1:0] cap_tdata;
    logic [KW-1:0] cap_tkeep;
    logic          cap_tlast;
    logic          cap_valid;
    logic          cap_ready = 1'b1;
    logic [31:0]   beat_cnt;
    logic [31:0]   byte_cnt;
    logic [31:0]   pkt_cnt;
    logic          in_pkt;
    logic          err;

    axi4stream_slv_sink #(
        .DATA_WIDTH (DW),
        .HAS_TLAST  (1),
        .HAS_TKEEP  (1),
        .FIFO_DEPTH (16),
        .CNT_WIDTH  (32)
    ) dut (
        .aclk        (aclk),
        .areset      (areset),
        .s_tdata     (s_tdata),
        .s_tkeep     (s_tkeep),
        .s_tlast     (s_tlast),
        .s_tvalid    (s_tvalid),
        .s_tready    (s_tready),
        .rdy_mode    (rdy_mode),
        .rdy_pattern (rdy_pattern),
        .cap_tdata   (cap_tdata),
        .cap_tkeep   (cap_tkeep),
        .cap_tlast   (cap_tlast),
        .cap_valid   (cap_valid),
        .cap_ready   (cap_ready),
        .beat_cnt    (beat_cnt),
        .byte_cnt    (byte_cnt),
        .pkt_cnt     (pkt_cnt),
        .in_pkt      (in_pkt),
        .err         (err)
    );

    always #5 aclk = ~aclk;

    int          total = 0;
    int          bad = 0;
    beat_t       sb[$];
    int unsigned m_beat = 0;
    int unsigned m_byte = 0;
    int unsigned m_pkt = 0;
    bit          m_in_pkt = 1'b0;
    int          acc_total = 0;
    int          consec = 0;
    bit          last_acc = 1'b0;
    bit          rnd_on = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: handshake not seen within %0d cycles", name, BOUND);
    endtask

    // Reference model: every accepted beat is queued and must reappear in order on cap_*.
    always @(negedge aclk) begin
        beat_t e;
        if (areset) begin
            chk("tready_in_reset", 64'(s_tready), 64'd0);
            sb.delete();
            m_beat = 0;
            m_byte = 0;
            m_pkt = 0;
            m_in_pkt = 1'b0;
            last_acc = 1'b0;
        end else begin
            chk("cap_valid", 64'(cap_valid), 64'(sb.size() != 0));
            if (cap_valid && cap_ready && sb.size() != 0) begin
                e = sb.pop_front();
                chk("cap_tdata", 64'(cap_tdata), 64'(e.d));
                chk("cap_tkeep", 64'(cap_tkeep), 64'(e.k));
                chk("cap_tlast", 64'(cap_tlast), 64'(e.l));
            end
            chk("beat_cnt", 64'(beat_cnt), 64'(m_beat));
            chk("byte_cnt", 64'(byte_cnt), 64'(m_byte));
            chk("pkt_cnt", 64'(pkt_cnt), 64'(m_pkt));
            chk("in_pkt", 64'(in_pkt), 64'(m_in_pkt));
            if (s_tvalid && s_tready) begin
                sb.push_back('{d: s_tdata, k: s_tkeep, l: s_tlast});
                m_beat++;
                m_byte += $countones(s_tkeep);
                if (s_tlast) m_pkt++;
                m_in_pkt = !s_tlast;
                acc_total++;
                if (last_acc) consec++;
                last_acc = 1'b1;
            end else begin
                last_acc = 1'b0;
            end
        end
    end

    task automatic do_reset();
        areset = 1'b1;
        s_tvalid = 1'b0;
        repeat (2) @(posedge aclk);
        #1 areset = 1'b0;
    endtask

    // Waits for the handshake of the beat currently driven; returns just after the accept edge.
    task automatic wait_accept(input string name);
        bit a;
        int cyc;
        cyc = 0;
        a = 1'b0;
        while (!a && cyc < BOUND) begin
            @(negedge aclk);
            a = s_tready;
            @(posedge aclk);
            #1;
            cyc++;
        end
        if (!a) timeout(name);
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
        s_tdata = d;
        s_tkeep = k;
        s_tlast = l;
        s_tvalid = 1'b1;
        wait_accept("send_beat");
        s_tvalid = 1'b0;
    endtask

    task automatic stream(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            s_tdata = DW'(base + i);
            s_tkeep = '1;
            s_tlast = (i == n - 1);
            s_tvalid = 1'b1;
            wait_accept("stream");
        end
        s_tvalid = 1'b0;
    endtask

    task automatic send_rand(input int n);
        for (int i = 0; i < n; i++) begin
            if (i % 50 == 0) begin
                rdy_mode = ($urandom_range(2) == 0) ? 2'd0 : ($urandom_range(1) ? 2'd2 : 2'd3);
                rdy_pattern = 8'($urandom) | 8'h01;
            end
            if ($urandom_range(3) == 0) begin
                s_tvalid = 1'b0;
                @(posedge aclk);
                #1;
            end
            s_tdata = $urandom;
            s_tkeep = 4'($urandom);
            s_tlast = ($urandom_range(3) == 0);
            s_tvalid = 1'b1;
            wait_accept("send_rand");
        end
        s_tvalid = 1'b0;
    endtask

    initial begin
        int a0;
        int ones;
        logic exp_err;
`ifdef AXIS_SINK_PATTERN_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        repeat (3) @(posedge aclk);
        #1 areset = 1'b0;
        chk("rst_tready", 64'(s_tready), 64'd0);
        chk("rst_cap_valid", 64'(cap_valid), 64'd0);
        chk("rst_beat", 64'(beat_cnt), 64'd0);
        chk("rst_byte", 64'(byte_cnt), 64'd0);
        chk("rst_pkt", 64'(pkt_cnt), 64'd0);
        chk("rst_in_pkt", 64'(in_pkt), 64'd0);
        chk("rst_err", 64'(err), 64'd0);

        // 20 beats straight through, always ready.
        rdy_mode = 2'd0;
        cap_ready = 1'b1;
        stream(20, 0);
        repeat (3) @(posedge aclk);
        #1;
        chk("m0_beat20", 64'(beat_cnt), 64'd20);
        chk("m0_byte80", 64'(byte_cnt), 64'd80);
        chk("m0_pkt1", 64'(pkt_cnt), 64'd1);

        // Pattern 1010_1010: half rate, never two accepts in a row.
        do_reset();
        rdy_mode = 2'd2;
        rdy_pattern = 8'b1010_1010;
        fork
            stream(40, 100);
            begin
                repeat (8) @(negedge aclk);
                #1;
                a0 = acc_total;
                consec = 0;
                repeat (32) @(negedge aclk);
                #1;
                chk("m2_accepts_32cyc", 64'(acc_total - a0), 64'd16);
                chk("m2_no_consecutive", 64'(consec), 64'd0);
            end
        join

        // Fill the FIFO with the sink stalled, then release it.
        do_reset();
        rdy_mode = 2'd0;
        cap_ready = 1'b0;
        a0 = acc_total;
        fork
            stream(20, 200);
            begin
                repeat (30) @(negedge aclk);
                #1;
                chk("full_accepts", 64'(acc_total - a0), 64'd16);
                chk("full_tready", 64'(s_tready), 64'd0);
                chk("full_cap_valid", 64'(cap_valid), 64'd1);
                @(posedge aclk);
                #1 cap_ready = 1'b1;
            end
        join
        repeat (20) @(posedge aclk);
        #1;
        chk("full_beat20", 64'(beat_cnt), 64'd20);
        chk("full_drained", 64'(cap_valid), 64'd0);

        // Byte qualifiers including a null last beat.
        do_reset();
        send_beat(32'h1122_3344, 4'hF, 1'b0);
        send_beat(32'h0000_5566, 4'h3, 1'b0);
        send_beat(32'h0, 4'h0, 1'b1);
        repeat (2) @(posedge aclk);
        #1;
        chk("keep_byte6", 64'(byte_cnt), 64'd6);
        chk("keep_beat3", 64'(beat_cnt), 64'd3);
        chk("keep_pkt1", 64'(pkt_cnt), 64'd1);

        // Reset in the middle of a packet.
        do_reset();
        cap_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_beat(DW'(i), 4'hF, 1'b0);
        chk("mid_in_pkt", 64'(in_pkt), 64'd1);
        chk("mid_beat3", 64'(beat_cnt), 64'd3);
        areset = 1'b1;
        @(posedge aclk);
        #1 areset = 1'b0;
        chk("mid_rst_beat", 64'(beat_cnt), 64'd0);
        chk("mid_rst_byte", 64'(byte_cnt), 64'd0);
        chk("mid_rst_in_pkt", 64'(in_pkt), 64'd0);
        chk("mid_rst_cap_valid", 64'(cap_valid), 64'd0);
        cap_ready = 1'b1;
        stream(5, 300);
        repeat (3) @(posedge aclk);
        #1;
        chk("mid_new_pkt", 64'(pkt_cnt), 64'd1);
        chk("mid_new_beat", 64'(beat_cnt), 64'd5);

        // Never-ready and LFSR modes with no traffic.
        do_reset();
        rdy_mode = 2'd1;
        repeat (2) @(posedge aclk);
        ones = 0;
        repeat (16) begin
            @(negedge aclk);
            if (s_tready) ones++;
        end
        chk("m1_never_ready", 64'(ones), 64'd0);
        rdy_mode = 2'd3;
        repeat (2) @(posedge aclk);
        ones = 0;
        repeat (64) begin
            @(negedge aclk);
            if (s_tready) ones++;
        end
        chk("m3_mixed_ready", 64'(ones > 0 && ones < 64), 64'd1);
        @(posedge aclk);
        #1;

        // Randomised traffic with random sink backpressure.
        do_reset();
        rnd_on = 1'b1;
        fork
            begin
                send_rand(300);
                rnd_on = 1'b0;
            end
            while (rnd_on) begin
                @(posedge aclk);
                #1 cap_ready = 1'($urandom_range(1));
            end
        join
        cap_ready = 1'b1;
        repeat (30) @(posedge aclk);
        #1;
        chk("rand_drained", 64'(cap_valid), 64'd0);

        // Byte-sequence checker: stream 0,1,2 then a skipped value.
        do_reset();
        rdy_mode = 2'd0;
        cap_ready = 1'b1;
        send_beat(32'd0, 4'h1, 1'b0);
        send_beat(32'd1, 4'h1, 1'b0);
        send_beat(32'd2, 4'h1, 1'b0);
        chk("pat_ok_err", 64'(err), 64'd0);
        send_beat(32'd4, 4'h1, 1'b1);
        chk("pat_bad_err", 64'(err), 64'(exp_err));
        send_beat(32'd5, 4'h1, 1'b1);
        chk("pat_sticky_err", 64'(err), 64'(exp_err));
        areset = 1'b1;
        @(posedge aclk);
        #1 areset = 1'b0;
        chk("pat_rst_err", 64'(err), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
